// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: instruction layout, opcodes,
// flag bit positions and the issue FSM state type.
package alu_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int INSTR_W    = 20;
    localparam int OPC_W      = 8;
    localparam int REG_AW     = 2;
    localparam int IMM_W      = 4;
    localparam int FLAGS_W    = 5;

    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 6;
    localparam int RSV_MSB = 5;
    localparam int RSV_LSB = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OPC_ADD  = 8'h00;
    localparam logic [OPC_W-1:0] OPC_SUB  = 8'h01;
    localparam logic [OPC_W-1:0] OPC_MUL  = 8'h02;
    localparam logic [OPC_W-1:0] OPC_EQ   = 8'h03;
    localparam logic [OPC_W-1:0] OPC_GT   = 8'h04;
    localparam logic [OPC_W-1:0] OPC_ADDI = 8'h09;
    localparam logic [OPC_W-1:0] OPC_SUBI = 8'h0A;
    localparam logic [OPC_W-1:0] OPC_MOV  = 8'h0B;

    // Bit positions inside the 5-bit {overflow, carry, zero, sign, parity} word.
    localparam int FLAG_OVF    = 4;
    localparam int FLAG_CARRY  = 3;
    localparam int FLAG_ZERO   = 2;
    localparam int FLAG_SIGN   = 1;
    localparam int FLAG_PARITY = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic opc_is_legal(input logic [OPC_W-1:0] opc);
        logic legal;
        case (opc)
            OPC_ADD, OPC_SUB, OPC_EQ, OPC_GT,
            OPC_ADDI, OPC_SUBI, OPC_MOV: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic opc_uses_imm(input logic [OPC_W-1:0] opc);
        return (opc == OPC_ADDI) || (opc == OPC_SUBI);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: one write port, two operand read ports and a debug read port,
// all reads combinational, contents cleared by the asynchronous reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 4
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              we_in,
    input  logic [REG_AW-1:0] waddr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [REG_AW-1:0] raddr1_in,
    output logic [DATA_W-1:0] rdata1_out,
    input  logic [REG_AW-1:0] raddr2_in,
    output logic [DATA_W-1:0] rdata2_out,
    input  logic [REG_AW-1:0] dbg_addr_in,
    output logic [DATA_W-1:0] dbg_data_out
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we_in && (waddr_in == REG_AW'(i))) begin
                    r_regs[i] <= wdata_in;
                end
            end
        end
    end

    // Addresses beyond NUM_REGS read back as zero.
    always_comb begin
        rdata1_out   = '0;
        rdata2_out   = '0;
        dbg_data_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr1_in == REG_AW'(i)) begin
                rdata1_out = r_regs[i];
            end
            if (raddr2_in == REG_AW'(i)) begin
                rdata2_out = r_regs[i];
            end
            if (dbg_addr_in == REG_AW'(i)) begin
                dbg_data_out = r_regs[i];
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction per two cycles, drives an external
// combinational ALU during EXEC and writes its result back during the EXEC->WB edge.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 4
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               instr_valid_in,
    output logic               instr_ready_out,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               alu_enable_out,
    output logic [OPC_W-1:0]   alu_opcode_out,
    output logic [DATA_W-1:0]  alu_input1_out,
    output logic [DATA_W-1:0]  alu_input2_out,
    input  logic [DATA_W-1:0]  alu_result_in,
    input  logic [FLAGS_W-1:0] alu_flags_in,
    output logic               result_valid_out,
    output logic [REG_AW-1:0]  result_rd_out,
    output logic [DATA_W-1:0]  result_data_out,
    output logic [FLAGS_W-1:0] flags_out,
    output logic               illegal_out,
    input  logic [REG_AW-1:0]  dbg_addr_in,
    output logic [DATA_W-1:0]  dbg_data_out
);

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        logic signed [IMM_W-1:0] imm_s;
        imm_s = signed'(imm);
        return DATA_W'(imm_s);
    endfunction

    state_t              r_state;
    logic                r_alu_en_p0;
    logic [OPC_W-1:0]    r_alu_opc_p0;
    logic [DATA_W-1:0]   r_alu_in1_p0;
    logic [DATA_W-1:0]   r_alu_in2_p0;
    logic [REG_AW-1:0]   r_rd_p0;
    logic                r_legal_p0;
    logic                r_vld_p1;
    logic                r_illegal_p1;
    logic [REG_AW-1:0]   r_rd_p1;
    logic [DATA_W-1:0]   r_data_p1;
    logic [FLAGS_W-1:0]  r_flags_p1;

    logic [OPC_W-1:0]    w_opc;
    logic [REG_AW-1:0]   w_rd;
    logic [REG_AW-1:0]   w_rs1;
    logic [REG_AW-1:0]   w_rs2;
    logic [IMM_W-1:0]    w_imm;
    logic [DATA_W-1:0]   w_rs1_data;
    logic [DATA_W-1:0]   w_rs2_data;
    logic                w_ready;
    logic                w_accept;
    logic                w_wr_en;
    logic                w_unused_rsvd;

    assign w_opc = instr_in[OPC_MSB:OPC_LSB];
    assign w_rd  = instr_in[RD_MSB:RD_LSB];
    assign w_rs1 = instr_in[RS1_MSB:RS1_LSB];
    assign w_rs2 = instr_in[RS2_MSB:RS2_LSB];
    assign w_imm = instr_in[IMM_MSB:IMM_LSB];
    assign w_unused_rsvd = ^instr_in[RSV_MSB:RSV_LSB];

    // Ready is forced low while reset is held so nothing is accepted during reset.
    assign w_ready  = (r_state != ST_EXEC) && !reset_in;
    assign w_accept = instr_valid_in && w_ready;
    assign w_wr_en  = (r_state == ST_EXEC) && r_legal_p0;

    alu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .we_in        (w_wr_en),
        .waddr_in     (r_rd_p0),
        .wdata_in     (alu_result_in),
        .raddr1_in    (w_rs1),
        .rdata1_out   (w_rs1_data),
        .raddr2_in    (w_rs2),
        .rdata2_out   (w_rs2_data),
        .dbg_addr_in  (dbg_addr_in),
        .dbg_data_out (dbg_data_out)
    );

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= ST_IDLE;
            r_alu_en_p0  <= 1'b0;
            r_alu_opc_p0 <= '0;
            r_alu_in1_p0 <= '0;
            r_alu_in2_p0 <= '0;
            r_rd_p0      <= '0;
            r_legal_p0   <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_illegal_p1 <= 1'b0;
            r_rd_p1      <= '0;
            r_data_p1    <= '0;
            r_flags_p1   <= '0;
        end else begin
            r_alu_en_p0  <= 1'b0;
            r_alu_opc_p0 <= '0;
            r_alu_in1_p0 <= '0;
            r_alu_in2_p0 <= '0;
            r_vld_p1     <= 1'b0;
            r_illegal_p1 <= 1'b0;
            case (r_state)
                ST_IDLE, ST_WB: begin
                    // issue -> EXEC: capture instruction and operands
                    if (w_accept) begin
                        r_state      <= ST_EXEC;
                        r_alu_en_p0  <= 1'b1;
                        r_alu_opc_p0 <= w_opc;
                        r_alu_in1_p0 <= w_rs1_data;
                        r_alu_in2_p0 <= opc_uses_imm(w_opc) ? sext_imm(w_imm) : w_rs2_data;
                        r_rd_p0      <= w_rd;
                        r_legal_p0   <= opc_is_legal(w_opc);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // EXEC -> WB: latch ALU result and flags for legal opcodes
                    r_state <= ST_WB;
                    if (r_legal_p0) begin
                        r_vld_p1   <= 1'b1;
                        r_rd_p1    <= r_rd_p0;
                        r_data_p1  <= alu_result_in;
                        r_flags_p1 <= alu_flags_in;
                    end else begin
                        r_illegal_p1 <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready_out  = w_ready;
    assign alu_enable_out   = r_alu_en_p0;
    assign alu_opcode_out   = r_alu_opc_p0;
    assign alu_input1_out   = r_alu_in1_p0;
    assign alu_input2_out   = r_alu_in2_p0;
    assign result_valid_out = r_vld_p1;
    assign illegal_out      = r_illegal_p1;
    assign result_rd_out    = r_rd_p1;
    assign result_data_out  = r_data_p1;
    assign flags_out        = r_flags_p1;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural 4-bit ALU attached.
module tb_alu_issue_ctrl;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic [19:0] instr_in;
    logic        alu_enable_out;
    logic [7:0]  alu_opcode_out;
    logic [3:0]  alu_input1_out;
    logic [3:0]  alu_input2_out;
    logic [3:0]  alu_result_in;
    logic [4:0]  alu_flags_in;
    logic        result_valid_out;
    logic [1:0]  result_rd_out;
    logic [3:0]  result_data_out;
    logic [4:0]  flags_out;
    logic        illegal_out;
    logic [1:0]  dbg_addr_in;
    logic [3:0]  dbg_data_out;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_ctrl #(.DATA_W(4), .NUM_REGS(4)) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .instr_valid_in   (instr_valid_in),
        .instr_ready_out  (instr_ready_out),
        .instr_in         (instr_in),
        .alu_enable_out   (alu_enable_out),
        .alu_opcode_out   (alu_opcode_out),
        .alu_input1_out   (alu_input1_out),
        .alu_input2_out   (alu_input2_out),
        .alu_result_in    (alu_result_in),
        .alu_flags_in     (alu_flags_in),
        .result_valid_out (result_valid_out),
        .result_rd_out    (result_rd_out),
        .result_data_out  (result_data_out),
        .flags_out        (flags_out),
        .illegal_out      (illegal_out),
        .dbg_addr_in      (dbg_addr_in),
        .dbg_data_out     (dbg_data_out)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural ALU: carry is carry-out for add, borrow for subtract.
    logic [4:0] m_res5;
    logic       m_ovf;
    logic       m_cy;
    always_comb begin
        m_res5 = '0;
        m_ovf  = 1'b0;
        m_cy   = 1'b0;
        case (alu_opcode_out)
            8'h00, 8'h09: begin
                m_res5 = {1'b0, alu_input1_out} + {1'b0, alu_input2_out};
                m_ovf  = (alu_input1_out[3] == alu_input2_out[3]) && (m_res5[3] != alu_input1_out[3]);
                m_cy   = m_res5[4];
            end
            8'h01, 8'h0A: begin
                m_res5 = {1'b0, alu_input1_out} - {1'b0, alu_input2_out};
                m_ovf  = (alu_input1_out[3] != alu_input2_out[3]) && (m_res5[3] != alu_input1_out[3]);
                m_cy   = alu_input1_out < alu_input2_out;
            end
            8'h03: m_res5 = {4'b0, alu_input1_out == alu_input2_out};
            8'h04: m_res5 = {4'b0, $signed(alu_input1_out) > $signed(alu_input2_out)};
            8'h0B: m_res5 = {1'b0, alu_input1_out};
            default: m_res5 = '0;
        endcase
        alu_result_in = m_res5[3:0];
        alu_flags_in  = {m_ovf, m_cy, m_res5[3:0] == 4'h0, m_res5[3], ^m_res5[3:0]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [19:0] enc(input logic [7:0] opc, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2,
                                        input logic [3:0] imm);
        return {opc, rd, rs1, rs2, 2'b11, imm};
    endfunction

    typedef struct {
        logic [7:0] opc;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [3:0] imm;
        logic [3:0] e_in1;
        logic [3:0] e_in2;
        logic       e_vld;
        logic       e_ill;
        logic [1:0] e_rd;
        logic [3:0] e_data;
        logic [4:0] e_flags;
        logic [1:0] dbg_a;
        logic [3:0] dbg_d;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8'h09, 2'd1, 2'd0, 2'd0, 4'h5, 4'h0, 4'h5, 1'b1, 1'b0, 2'd1, 4'h5, 5'b00000, 2'd1, 4'h5};
        vecs[1] = '{8'h00, 2'd2, 2'd1, 2'd1, 4'h0, 4'h5, 4'h5, 1'b1, 1'b0, 2'd2, 4'hA, 5'b10010, 2'd2, 4'hA};
        vecs[2] = '{8'h02, 2'd3, 2'd1, 2'd2, 4'h0, 4'h5, 4'hA, 1'b0, 1'b1, 2'd2, 4'hA, 5'b10010, 2'd3, 4'h0};
        vecs[3] = '{8'h0A, 2'd3, 2'd1, 2'd0, 4'h7, 4'h5, 4'h7, 1'b1, 1'b0, 2'd3, 4'hE, 5'b01011, 2'd3, 4'hE};
        vecs[4] = '{8'h04, 2'd0, 2'd1, 2'd3, 4'h0, 4'h5, 4'hE, 1'b1, 1'b0, 2'd0, 4'h1, 5'b00001, 2'd0, 4'h1};
        vecs[5] = '{8'h03, 2'd0, 2'd0, 2'd2, 4'h0, 4'h1, 4'hA, 1'b1, 1'b0, 2'd0, 4'h0, 5'b00100, 2'd0, 4'h0};
        vecs[6] = '{8'h0B, 2'd2, 2'd3, 2'd0, 4'h0, 4'hE, 4'h0, 1'b1, 1'b0, 2'd2, 4'hE, 5'b00011, 2'd2, 4'hE};
        vecs[7] = '{8'h01, 2'd1, 2'd1, 2'd2, 4'h0, 4'h5, 4'hE, 1'b1, 1'b0, 2'd1, 4'h7, 5'b01001, 2'd1, 4'h7};
        vecs[8] = '{8'h09, 2'd3, 2'd3, 2'd0, 4'hF, 4'hE, 4'hF, 1'b1, 1'b0, 2'd3, 4'hD, 5'b01011, 2'd3, 4'hD};
        vecs[9] = '{8'hFF, 2'd0, 2'd1, 2'd1, 4'h0, 4'h7, 4'h7, 1'b0, 1'b1, 2'd3, 4'hD, 5'b01011, 2'd0, 4'h0};

        reset_in       = 1'b1;
        instr_valid_in = 1'b0;
        instr_in       = '0;
        dbg_addr_in    = '0;
        step();
        step();
        chk("rst_ready", instr_ready_out, 0);
        chk("rst_vld", result_valid_out, 0);
        chk("rst_ill", illegal_out, 0);
        chk("rst_en", alu_enable_out, 0);
        chk("rst_flags", flags_out, 0);
        chk("rst_data", result_data_out, 0);
        chk("rst_rd", result_rd_out, 0);
        for (int r = 0; r < 4; r++) begin
            dbg_addr_in = 2'(r);
            #1;
            chk("rst_reg", dbg_data_out, 0);
        end
        reset_in = 1'b0;
        #1;
        chk("post_rst_ready", instr_ready_out, 1);

        for (int i = 0; i < 10; i++) begin
            instr_in = enc(vecs[i].opc, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            instr_valid_in = 1'b1;
            step();
            instr_valid_in = 1'b0;
            chk("exec_en", alu_enable_out, 1);
            chk("exec_ready", instr_ready_out, 0);
            chk("exec_opc", alu_opcode_out, vecs[i].opc);
            chk("exec_in1", alu_input1_out, vecs[i].e_in1);
            chk("exec_in2", alu_input2_out, vecs[i].e_in2);
            step();
            chk("wb_ready", instr_ready_out, 1);
            chk("wb_en", alu_enable_out, 0);
            chk("wb_opc", alu_opcode_out, 0);
            chk("wb_vld", result_valid_out, vecs[i].e_vld);
            chk("wb_ill", illegal_out, vecs[i].e_ill);
            chk("wb_rd", result_rd_out, vecs[i].e_rd);
            chk("wb_data", result_data_out, vecs[i].e_data);
            chk("wb_flags", flags_out, vecs[i].e_flags);
            dbg_addr_in = vecs[i].dbg_a;
            step();
            chk("idle_vld", result_valid_out, 0);
            chk("idle_ill", illegal_out, 0);
            chk("idle_dbg", dbg_data_out, vecs[i].dbg_d);
        end

        // Back-to-back with valid held high; each instruction depends on the previous one.
        // Registers now: r0=0 r1=7 r2=E r3=D.
        instr_valid_in = 1'b1;
        instr_in = enc(8'h09, 2'd1, 2'd0, 2'd0, 4'h3);
        step();
        chk("b2b1_en", alu_enable_out, 1);
        chk("b2b1_ready", instr_ready_out, 0);
        chk("b2b1_in2", alu_input2_out, 4'h3);
        instr_in = enc(8'h01, 2'd2, 2'd1, 2'd0, 4'h0);
        step();
        chk("b2b1_wb_ready", instr_ready_out, 1);
        chk("b2b1_wb_vld", result_valid_out, 1);
        chk("b2b1_wb_data", result_data_out, 4'h3);
        step();
        chk("b2b2_en", alu_enable_out, 1);
        chk("b2b2_opc", alu_opcode_out, 8'h01);
        chk("b2b2_in1_fwd", alu_input1_out, 4'h3);
        chk("b2b2_in2", alu_input2_out, 4'h0);
        instr_in = enc(8'h00, 2'd3, 2'd2, 2'd1, 4'h0);
        step();
        chk("b2b2_wb_rd", result_rd_out, 2'd2);
        chk("b2b2_wb_data", result_data_out, 4'h3);
        step();
        instr_valid_in = 1'b0;
        chk("b2b3_in1", alu_input1_out, 4'h3);
        chk("b2b3_in2", alu_input2_out, 4'h3);
        step();
        chk("b2b3_wb_data", result_data_out, 4'h6);
        chk("b2b3_wb_vld", result_valid_out, 1);
        step();
        chk("b2b_idle_en", alu_enable_out, 0);

        // Reset arriving during EXEC of MOV rd=3 aborts it.
        instr_in = enc(8'h0B, 2'd3, 2'd1, 2'd0, 4'h0);
        instr_valid_in = 1'b1;
        step();
        instr_valid_in = 1'b0;
        chk("mov_en", alu_enable_out, 1);
        chk("mov_in1", alu_input1_out, 4'h3);
        reset_in = 1'b1;
        #1;
        chk("arst_en", alu_enable_out, 0);
        chk("arst_ready", instr_ready_out, 0);
        step();
        dbg_addr_in = 2'd3;
        #1;
        chk("arst_vld", result_valid_out, 0);
        chk("arst_ill", illegal_out, 0);
        chk("arst_r3", dbg_data_out, 0);
        reset_in = 1'b0;
        #1;
        chk("arst_rel_ready", instr_ready_out, 1);
        step();
        chk("arst_idle_vld", result_valid_out, 0);
        chk("arst_idle_en", alu_enable_out, 0);
        chk("arst_idle_ready", instr_ready_out, 1);
        chk("arst_r3_after", dbg_data_out, 0);

        instr_in = enc(8'h09, 2'd0, 2'd0, 2'd0, 4'h2);
        instr_valid_in = 1'b1;
        step();
        instr_valid_in = 1'b0;
        chk("restart_en", alu_enable_out, 1);
        chk("restart_in2", alu_input2_out, 4'h2);
        step();
        chk("restart_vld", result_valid_out, 1);
        chk("restart_data", result_data_out, 4'h2);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
